// File: rtl/dme_interrogation_ctrl.sv
// DME interrogation controller: fires periodic receiver measurements, filters
// replies against a timeout window and tracks search/track (lock) status.
module dme_interrogation_ctrl #(
    parameter int unsigned PRF_PERIOD  = 100,
    parameter int unsigned TIMEOUT     = 60,
    parameter int unsigned REPLY_DELAY = 50,
    parameter int unsigned LOCK_COUNT  = 3,
    parameter int unsigned MISS_LIMIT  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    output logic        start,
    input  logic        rx_valid,
    input  logic [31:0] rx_p1,
    output logic [31:0] range_out,
    output logic        range_valid,
    output logic        locked,
    output logic [1:0]  state
);

    localparam int unsigned CNT_W  = $clog2(PRF_PERIOD + 1);
    localparam int unsigned STRK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STRK_W-1:0]   hit_q, hit_d;
    logic [STRK_W-1:0]   miss_q, miss_d;
    logic                locked_q, locked_d;
    logic [31:0]         range_q, range_d;
    logic                rv_q, rv_d;
    logic                start_q, start_d;
    logic                en_q;
    logic                is_hit, is_miss;

    // State, counters and all outputs; cleared asynchronously so a reset
    // mid-WAIT simply discards the outstanding measurement.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            range_q  <= '0;
            rv_q     <= 1'b0;
            start_q  <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            range_q  <= range_d;
            rv_q     <= rv_d;
            start_q  <= start_d;
            en_q     <= enable;
        end
    end

    // Next-state, reply classification, hit/miss streaks and lock decision.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        hit_d    = hit_q;
        miss_d   = miss_q;
        locked_d = locked_q;
        range_d  = range_q;
        rv_d     = 1'b0;
        is_hit   = 1'b0;
        is_miss  = 1'b0;

        // Lock follows the streak counters one cycle after they saturate.
        if (miss_q == STRK_W'(MISS_LIMIT)) begin
            locked_d = 1'b0;
        end else if (hit_q == STRK_W'(LOCK_COUNT)) begin
            locked_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // en_q gives one full IDLE cycle after enable is first seen.
                if (en_q) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A reply wins over a timeout landing in the same cycle.
                if (rx_valid) begin
                    if (rx_p1 >= 32'(REPLY_DELAY)) begin
                        is_hit = 1'b1;
                    end else begin
                        is_miss = 1'b1;
                    end
                    state_d = ST_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    is_miss = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(PRF_PERIOD - 1)) begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (is_hit) begin
            range_d = rx_p1 - 32'(REPLY_DELAY);
            rv_d    = 1'b1;
            miss_d  = '0;
            if (hit_q != STRK_W'(LOCK_COUNT)) begin
                hit_d = hit_q + STRK_W'(1);
            end
        end

        if (is_miss) begin
            hit_d = '0;
            if (miss_q != STRK_W'(MISS_LIMIT)) begin
                miss_d = miss_q + STRK_W'(1);
            end
        end

        // Dropping enable aborts everything except the last range.
        if (!enable) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            hit_d    = '0;
            miss_d   = '0;
            locked_d = 1'b0;
            range_d  = range_q;
            rv_d     = 1'b0;
        end
    end

    // Start is registered yet coincides with the ARM cycle.
    always_comb begin
        start_d = (state_d == ST_ARM);
    end

    assign start       = start_q;
    assign range_out   = range_q;
    assign range_valid = rv_q;
    assign locked      = locked_q;
    assign state       = state_q;

endmodule

// File: tb/tb_dme_interrogation_ctrl.sv
// Bench for dme_interrogation_ctrl: event-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_dme_interrogation_ctrl;

    localparam int PRF  = 100;
    localparam int TO   = 60;
    localparam int RD   = 50;
    localparam int LCNT = 3;
    localparam int MLIM = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        start;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_p1 = 32'd0;
    logic [31:0] range_out;
    logic        range_valid;
    logic        locked;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;

    dme_interrogation_ctrl #(
        .PRF_PERIOD (PRF),
        .TIMEOUT    (TO),
        .REPLY_DELAY(RD),
        .LOCK_COUNT (LCNT),
        .MISS_LIMIT (MLIM)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_p1      (rx_p1),
        .range_out  (range_out),
        .range_valid(range_valid),
        .locked     (locked),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since last start pulse, an open reply window,
    // unbounded hit/miss streaks and the last accepted range.
    bit          m_active = 0;
    bit          m_seen   = 0;
    bit          m_open   = 0;
    int          m_t      = 0;
    int          m_hits   = 0;
    int          m_misses = 0;
    bit          m_locked = 0;
    bit          m_rv     = 0;
    logic [31:0] m_range  = 32'd0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active = 0; m_seen = 0; m_open = 0; m_t = 0;
            m_hits = 0; m_misses = 0; m_locked = 0; m_rv = 0; m_range = 32'd0;
        end else if (!enable) begin
            m_active = 0; m_seen = 0; m_open = 0; m_t = 0;
            m_hits = 0; m_misses = 0; m_locked = 0; m_rv = 0;
        end else begin
            m_rv = 0;
            if (m_misses >= MLIM) m_locked = 0;
            else if (m_hits >= LCNT) m_locked = 1;
            if (!m_active) begin
                if (m_seen) begin
                    m_active = 1;
                    m_t = 0;
                end
                m_seen = 1;
            end else if (m_t == 0) begin
                m_open = 1;
                m_t = 1;
            end else begin
                if (m_open) begin
                    if (rx_valid) begin
                        m_open = 0;
                        if (rx_p1 >= 32'(RD)) begin
                            m_hits++; m_misses = 0; m_range = rx_p1 - 32'(RD); m_rv = 1;
                        end else begin
                            m_misses++; m_hits = 0;
                        end
                    end else if (m_t == TO) begin
                        m_open = 0;
                        m_misses++; m_hits = 0;
                    end
                end
                m_t = (m_t == PRF - 1) ? 0 : m_t + 1;
            end
        end
    end

    // Compare all outputs against the model in the middle of every cycle.
    always @(negedge clk) begin
        logic [1:0] exp_state;
        if (!m_active)      exp_state = 2'd0;
        else if (m_t == 0)  exp_state = 2'd1;
        else if (m_open)    exp_state = 2'd2;
        else                exp_state = 2'd3;
        chk("start", 32'(start), 32'(m_active && m_t == 0));
        chk("state", 32'(state), 32'(exp_state));
        chk("range_out", range_out, m_range);
        chk("range_valid", 32'(range_valid), 32'(m_rv));
        chk("locked", 32'(locked), 32'(m_locked));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Advance to the next start pulse; leaves the bench in the ARM cycle.
    task automatic wait_start(output int waited);
        waited = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (start) begin
                waited = i;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL wait_start: no start within 300 cycles, expected one");
    endtask

    task automatic pulse_rx(input logic [31:0] val);
        rx_valid = 1'b1;
        rx_p1    = val;
        tick();
        rx_valid = 1'b0;
        rx_p1    = 32'd0;
    endtask

    // Reply sampled while the period counter equals k.
    task automatic reply_at(input int k, input logic [31:0] val);
        int w;
        wait_start(w);
        repeat (k) tick();
        pulse_rx(val);
    endtask

    initial begin
        int w;
        int nstart;

        // Reset state
        repeat (3) tick();
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_range", range_out, 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        resetn = 1'b1;
        repeat (2) tick();
        chk("idle_state", 32'(state), 32'd0);

        // First start comes two edges after enable is sampled
        enable = 1'b1;
        tick();
        chk("first_edge_start", 32'(start), 32'd0);
        tick();
        chk("second_edge_start", 32'(start), 32'd1);
        chk("second_edge_state", 32'(state), 32'd1);

        // No replies: starts every PRF cycles, never locked
        wait_start(w);
        chk("prf_spacing_a", 32'(w), 32'd100);
        wait_start(w);
        chk("prf_spacing_b", 32'(w), 32'd100);
        chk("search_locked", 32'(locked), 32'd0);

        // Three hits at count 20 with 1250 -> range 1200, then lock
        reply_at(20, 32'd1250);
        chk("hit1_rv", 32'(range_valid), 32'd1);
        chk("hit1_range", range_out, 32'd1200);
        reply_at(20, 32'd1250);
        reply_at(20, 32'd1250);
        chk("hit3_rv", 32'(range_valid), 32'd1);
        repeat (2) tick();
        chk("lock_after_3", 32'(locked), 32'd1);

        // Two timeouts drop lock, range is held
        wait_start(w);
        wait_start(w);
        chk("one_timeout_locked", 32'(locked), 32'd1);
        wait_start(w);
        chk("two_timeouts_locked", 32'(locked), 32'd0);
        chk("timeout_range", range_out, 32'd1200);

        // Short reply is a miss; a reply in GAP is ignored
        reply_at(20, 32'd30);
        chk("short_rv", 32'(range_valid), 32'd0);
        repeat (50) tick();
        pulse_rx(32'd5000);
        chk("gap_rv", 32'(range_valid), 32'd0);
        tick();
        chk("gap_range", range_out, 32'd1200);

        // Timeout boundary: count 60 accepted, count 61 ignored
        reply_at(60, 32'd1300);
        chk("edge60_rv", 32'(range_valid), 32'd1);
        chk("edge60_range", range_out, 32'd1250);
        reply_at(61, 32'd1400);
        chk("edge61_rv", 32'(range_valid), 32'd0);
        chk("edge61_range", range_out, 32'd1250);

        // Relock, then drop enable mid-WAIT
        reply_at(20, 32'd1250);
        reply_at(20, 32'd1250);
        reply_at(20, 32'd1250);
        repeat (2) tick();
        chk("relock", 32'(locked), 32'd1);
        wait_start(w);
        repeat (10) tick();
        enable = 1'b0;
        tick();
        chk("dis_state", 32'(state), 32'd0);
        chk("dis_locked", 32'(locked), 32'd0);
        nstart = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (start) nstart++;
        end
        chk("dis_no_start", 32'(nstart), 32'd0);
        chk("dis_range", range_out, 32'd1200);

        // Re-enable: hit streak restarts from zero
        enable = 1'b1;
        reply_at(20, 32'd1250);
        reply_at(20, 32'd1250);
        repeat (2) tick();
        chk("reen_two_hits_locked", 32'(locked), 32'd0);
        reply_at(20, 32'd1250);
        repeat (2) tick();
        chk("reen_three_hits_locked", 32'(locked), 32'd1);

        // Asynchronous reset mid-WAIT while locked
        wait_start(w);
        repeat (10) tick();
        resetn = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_range", range_out, 32'd0);
        chk("arst_start", 32'(start), 32'd0);
        repeat (3) tick();
        resetn = 1'b1;
        reply_at(20, 32'd1100);
        chk("post_rst_range", range_out, 32'd1050);
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
